cis_line_capture: RTL
=====================

// Module: cis_line_capture
// PURPOSE
//  Downstream of the CIS controller. Frames ADC pixel samples into colour-tagged line packets.
//  Line start comes from SI_TOGGLE edges; colour comes from SI_CNT.
//  Output is a valid/ready stream: one header beat, then PIX_CNT pixel beats. Stream feeds the USB/packet layer.
//  An internal FIFO absorbs back-pressure. Lines that cannot fit are dropped whole, so framing is never broken.
// PARAMETERS
//  ADC_W     8     ADC sample width (<=16); zero-extended to 16 bits on M_DATA
//  PIX_SKIP  60    leading ADC samples discarded after each line start (dark/dummy pixels)
//  PIX_CNT   2592  pixel samples captured per line
//  FIFO_AW   12    FIFO address width; 2**FIFO_AW must be >= PIX_CNT+1
// PORTS
//  CLK        in   1      system clock
//  RST        in   1      synchronous, active-high reset
//  EN         in   1      capture enable; sampled only at a line start
//  SI_TOGGLE  in   1      toggles once per sensor line start
//  SI_CNT     in   2      colour index of the line: 0=R, 1=G, 2=B
//  ADC_DATA   in   ADC_W  pixel sample
//  ADC_VALID  in   1      one-cycle strobe per sample
//  TEST_EN    in   1      select test pattern (effective only with the macro)
//  M_DATA     out  16     header {SI_CNT[1:0], LINE_NUM[13:0]} or pixel sample
//  M_HDR      out  1      current beat is a header
//  M_LAST     out  1      current beat is the last pixel of the line
//  M_VALID    out  1      stream valid
//  M_READY    in   1      stream ready; transfer when M_VALID & M_READY
//  DROP_CNT   out  16     lines dropped for lack of FIFO space; saturates at 16'hFFFF
//  SHORT_ERR  out  1      sticky: a line start arrived before PIX_CNT samples were captured
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; LINE_NUM=0; FSM=IDLE. Reset mid-line discards FIFO contents.
//  - Line-start detect: r_si_t <= SI_TOGGLE; start = SI_TOGGLE ^ r_si_t. SI_CNT is latched on start.
//  - FSM IDLE, on start:
//    - EN=0: stay IDLE.
//    - FIFO free < PIX_CNT+1: DROP_CNT++ (saturating), stay IDLE; LINE_NUM unchanged.
//    - Otherwise: write header next cycle, go to SKIP.
//  - SKIP: count ADC_VALID; after PIX_SKIP samples go to CAPT. With PIX_SKIP=0 go straight to CAPT.
//  - CAPT: each ADC_VALID writes one beat to the FIFO, latency 1 cycle. The PIX_CNT-th beat has LAST=1.
//    After it: LINE_NUM++ (14-bit wrap), go to IDLE.
//  - start during SKIP/CAPT: set SHORT_ERR. Go to PAD and write zero beats, one per clock,
//    until PIX_CNT pixels are in (LAST on the final one). ADC_VALID is ignored in PAD.
//    Then LINE_NUM++ and process the pending start exactly as in IDLE.
//  - start during PAD: pending flag is set once. Later starts overwrite the latched colour and set SHORT_ERR.
//  - Space is reserved at accept time, so the FIFO never overflows. A write with FIFO full is a design error (assertion).
//  - FIFO is first-word-fall-through; M_VALID rises 1 cycle after the first write into an empty FIFO.
//  - M_DATA/M_HDR/M_LAST hold stable while M_VALID=1 and M_READY=0.
//  - Simultaneous write and read on the same cycle are both honoured; occupancy is unchanged.
// CONFIGURATION
//  - CIS_LINE_CAPTURE_TEST_PATTERN_EN defined: with TEST_EN=1, pixel beats carry the pixel index 0..PIX_CNT-1 (16 bits)
//    instead of ADC_DATA. Timing is still paced by ADC_VALID. TEST_EN is sampled at the line start.
//  - Macro undefined: TEST_EN is ignored and the pattern logic is absent.
// STRUCTURE
//  - Shared package cis_pkg: colour codes R/G/B; LEDS_CNT=2592; LINE_NUM width 14; FSM state enum IDLE/SKIP/CAPT/PAD.
//  - One sub-module: cis_sync_fifo (18-bit: data16+hdr+last; FWFT; exposes free-count output).
//  - FSM, counters and edge detect live in this module.
// TESTING
//  - Reset, then 3 starts with SI_CNT=0,1,2, 2652 ADC_VALIDs each, M_READY=1 -> 3 packets.
//    Headers 0x0000/0x4001/0x8002; 2592 pixels each; M_LAST on beat 2593.
//  - M_READY=0 for 2 lines with FIFO_AW=12 -> line 1 accepted, line 2 dropped, DROP_CNT=1.
//    Then M_READY=1 -> line 1 drains intact.
//  - Start after 1000 captured pixels -> SHORT_ERR=1; line padded with 1592 zeros + LAST; next header LINE_NUM+1.
//  - EN=0 at start, EN=1 mid-line -> no output until the following start.
//  - Macro defined, TEST_EN=1 -> pixel beats 0,1,...,2591. Macro undefined -> ADC_DATA passed through.
//  - Assert RST mid-CAPT -> next cycle M_VALID=0, DROP_CNT=0, SHORT_ERR=0; next packet header LINE_NUM=0.

Source files
------------

// File: rtl/cis_pkg.sv
// Shared definitions for the CIS line-capture block: colour codes, the
// sensor line length, the line-number width and the capture FSM states.
package cis_pkg;

  localparam logic [1:0] COL_R = 2'd0;
  localparam logic [1:0] COL_G = 2'd1;
  localparam logic [1:0] COL_B = 2'd2;

  localparam int LEDS_CNT   = 2592;
  localparam int LINE_NUM_W = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    CAPT = 2'd2,
    PAD  = 2'd3
  } state_t;

  // Header beat layout: colour in the top two bits, line number below.
  function automatic logic [15:0] make_header(input logic [1:0] col,
                                              input logic [LINE_NUM_W-1:0] line_num);
    return {col, line_num};
  endfunction

endpackage

// File: rtl/cis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a free-space count.
// The head word is presented combinationally whenever the FIFO is non-empty,
// so rd_valid rises the cycle after the first write into an empty FIFO.
module cis_sync_fifo #(
  parameter int AW = 12,
  parameter int W  = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic [AW:0]   free_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, do_wr, do_rd;

  // Pointer and occupancy bookkeeping; a write and a read together leave the count unchanged.
  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_wr    = wr_en & ~full;
    do_rd    = rd_en & ~empty;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    rd_valid = ~empty;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    free_cnt = (AW+1)'(DEPTH) - count_q;
  end

  // Pointer/count registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Space is reserved upstream before a line is accepted, so a write into a full FIFO is a bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/cis_line_capture.sv
// CIS line capture: frames ADC samples into colour-tagged line packets
// (one header beat + PIX_CNT pixel beats) buffered in an FWFT FIFO.
// Optional feature macro: CIS_LINE_CAPTURE_TEST_PATTERN_EN (pixel-index test pattern).
//
// Stream handshake: a beat transfers on a rising CLK edge where M_VALID and
// M_READY are both 1; while M_VALID=1 and M_READY=0 the beat (M_DATA, M_HDR,
// M_LAST) holds stable, and M_VALID never drops before the beat transfers.
module cis_line_capture
  import cis_pkg::*;
#(
  parameter int ADC_W    = 8,
  parameter int PIX_SKIP = 60,
  parameter int PIX_CNT  = LEDS_CNT,
  parameter int FIFO_AW  = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SI_TOGGLE,
  input  logic [1:0]       SI_CNT,
  input  logic [ADC_W-1:0] ADC_DATA,
  input  logic             ADC_VALID,
  input  logic             TEST_EN,
  output logic [15:0]      M_DATA,
  output logic             M_HDR,
  output logic             M_LAST,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [15:0]      DROP_CNT,
  output logic             SHORT_ERR,
  output state_t           DBG_STATE
);

  localparam logic [15:0] LAST_IDX = 16'(PIX_CNT - 1);
  localparam logic [15:0] SKIP_N   = 16'(PIX_SKIP);
  localparam int          NEED     = PIX_CNT + 1;
  localparam state_t      FIRST_ST = (PIX_SKIP == 0) ? CAPT : SKIP;

  state_t                state_q, state_d;
  logic                  si_t_q, si_t_d;
  logic [1:0]            color_q, color_d;
  logic [LINE_NUM_W-1:0] line_num_q, line_num_d;
  logic [15:0]           skip_cnt_q, skip_cnt_d;
  logic [15:0]           pix_cnt_q, pix_cnt_d;
  logic                  pend_q, pend_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic                  short_err_q, short_err_d;
  logic                  wr_en_q, wr_en_d;
  logic                  wr_hdr_q, wr_hdr_d;
  logic                  wr_last_q, wr_last_d;
  logic [15:0]           wr_data_q, wr_data_d;
`ifdef CIS_LINE_CAPTURE_TEST_PATTERN_EN
  logic                  test_q, test_d;
`else
  logic                  unused_test_en;
  assign unused_test_en = TEST_EN;
`endif

  logic        start, room_ok, pix_last;
  logic [15:0] pixel;
  logic [17:0] rd_word;
  logic [FIFO_AW:0] free_cnt;

  // Line-start detect, accept/drop decision and the capture FSM next state.
  always_comb begin
    start   = SI_TOGGLE ^ si_t_q;
    // A beat still sitting in the write register is not yet counted by the FIFO.
    room_ok = (32'(free_cnt) >= 32'(NEED) + 32'(wr_en_q));
    pix_last = (pix_cnt_q == LAST_IDX);
`ifdef CIS_LINE_CAPTURE_TEST_PATTERN_EN
    pixel   = test_q ? pix_cnt_q : 16'(ADC_DATA);
    test_d  = test_q;
`else
    pixel   = 16'(ADC_DATA);
`endif
    state_d     = state_q;
    si_t_d      = SI_TOGGLE;
    color_d     = start ? SI_CNT : color_q;
    line_num_d  = line_num_q;
    skip_cnt_d  = skip_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    pend_d      = pend_q;
    drop_cnt_d  = drop_cnt_q;
    short_err_d = short_err_q;
    wr_en_d     = 1'b0;
    wr_hdr_d    = 1'b0;
    wr_last_d   = 1'b0;
    wr_data_d   = '0;
    case (state_q)
      IDLE: begin
        if (start || pend_q) begin
          pend_d = 1'b0;
          if (!EN) begin
            state_d = IDLE;
          end else if (!room_ok) begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            wr_en_d    = 1'b1;
            wr_hdr_d   = 1'b1;
            wr_data_d  = make_header(start ? SI_CNT : color_q, line_num_q);
            skip_cnt_d = '0;
            pix_cnt_d  = '0;
            state_d    = FIRST_ST;
`ifdef CIS_LINE_CAPTURE_TEST_PATTERN_EN
            test_d     = TEST_EN;
`endif
          end
        end
      end
      SKIP: begin
        if (start) begin
          short_err_d = 1'b1;
          pend_d      = 1'b1;
          state_d     = PAD;
        end else if (ADC_VALID) begin
          skip_cnt_d = skip_cnt_q + 16'd1;
          if (skip_cnt_q == SKIP_N - 16'd1) state_d = CAPT;
        end
      end
      CAPT: begin
        if (start) begin
          short_err_d = 1'b1;
          pend_d      = 1'b1;
          state_d     = PAD;
        end else if (ADC_VALID) begin
          wr_en_d   = 1'b1;
          wr_data_d = pixel;
          wr_last_d = pix_last;
          pix_cnt_d = pix_cnt_q + 16'd1;
          if (pix_last) begin
            line_num_d = line_num_q + LINE_NUM_W'(1);
            state_d    = IDLE;
          end
        end
      end
      PAD: begin
        // Fill the rest of a short line with zeros so the packet length never changes.
        wr_en_d   = 1'b1;
        wr_last_d = pix_last;
        pix_cnt_d = pix_cnt_q + 16'd1;
        if (pix_last) begin
          line_num_d = line_num_q + LINE_NUM_W'(1);
          state_d    = IDLE;
        end
        if (start) begin
          short_err_d = 1'b1;
          pend_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single state register for FSM, counters, edge detect and the FIFO write stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      si_t_q      <= 1'b0;
      color_q     <= '0;
      line_num_q  <= '0;
      skip_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      pend_q      <= 1'b0;
      drop_cnt_q  <= '0;
      short_err_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_hdr_q    <= 1'b0;
      wr_last_q   <= 1'b0;
      wr_data_q   <= '0;
`ifdef CIS_LINE_CAPTURE_TEST_PATTERN_EN
      test_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      si_t_q      <= si_t_d;
      color_q     <= color_d;
      line_num_q  <= line_num_d;
      skip_cnt_q  <= skip_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      pend_q      <= pend_d;
      drop_cnt_q  <= drop_cnt_d;
      short_err_q <= short_err_d;
      wr_en_q     <= wr_en_d;
      wr_hdr_q    <= wr_hdr_d;
      wr_last_q   <= wr_last_d;
      wr_data_q   <= wr_data_d;
`ifdef CIS_LINE_CAPTURE_TEST_PATTERN_EN
      test_q      <= test_d;
`endif
    end
  end

  cis_sync_fifo #(.AW(FIFO_AW), .W(18)) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .wr_en    (wr_en_q),
    .wr_data  ({wr_hdr_q, wr_last_q, wr_data_q}),
    .rd_en    (M_READY),
    .rd_data  (rd_word),
    .rd_valid (M_VALID),
    .free_cnt (free_cnt)
  );

  assign M_HDR     = rd_word[17];
  assign M_LAST    = rd_word[16];
  assign M_DATA    = rd_word[15:0];
  assign DROP_CNT  = drop_cnt_q;
  assign SHORT_ERR = short_err_q;
  assign DBG_STATE = state_q;

endmodule
